// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between requesters and the shared ALU.
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [3*NUM_REQ-1:0] req_op;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [7:0]      rsp_result;
    logic            rsp_zero;
    logic            rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
        input  rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result,
        output rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 8-bit ALU among NUM_REQ requesters.
// Grant -> EXEC (compute) -> RESP (hold registered result until accepted).
module alu_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_arbiter_if.slave bus,
    output logic       busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_n;

    logic [ID_W-1:0] last_grant;

    logic            win_ok;
    logic [ID_W-1:0] win_id;
    logic [7:0]      win_a;
    logic [7:0]      win_b;
    logic [2:0]      win_op;
    logic            grant;

    logic [7:0]      cap_a;
    logic [7:0]      cap_b;
    logic [2:0]      cap_op;
    logic [ID_W-1:0] cap_id;

    logic [7:0]      alu_y;
    logic            alu_err;

    logic [7:0]      res_q;
    logic            zero_q;
    logic            err_q;
    logic [ID_W-1:0] id_q;

    // Round-robin pick: nearest valid requester after last_grant wins.
    always_comb begin
        win_ok = 1'b0;
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] &&
                    i == (int'(last_grant) + k) % NUM_REQ) begin
                    win_ok = 1'b1;
                    win_id = ID_W'(i);
                    win_a  = bus.req_a[8*i +: 8];
                    win_b  = bus.req_b[8*i +: 8];
                    win_op = bus.req_op[3*i +: 3];
                end
            end
        end
    end

    // A grant only happens when the single operand slot is free.
    always_comb begin
        grant = !rst && win_ok &&
                (state == IDLE || (state == RESP && bus.rsp_ready));
        bus.req_ready = '0;
        if (grant)
            bus.req_ready = NUM_REQ'(1) << win_id;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (grant) state_n = EXEC;
            EXEC: state_n = RESP;
            RESP: if (bus.rsp_ready) state_n = grant ? EXEC : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ALU on the captured operands; illegal opcodes yield 0 with err.
    always_comb begin
        alu_y   = 8'h00;
        alu_err = 1'b0;
        unique case (cap_op)
            3'b000: alu_y = cap_a + cap_b;
            3'b001: alu_y = cap_a - cap_b;
            3'b010: alu_y = cap_a & cap_b;
            3'b011: alu_y = cap_a | cap_b;
            3'b100: alu_y = cap_a ^ cap_b;
            3'b101: alu_y = ~(cap_a | cap_b);
            default: alu_err = 1'b1;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            if (grant)
                last_grant <= win_id;
        end
    end

    // Operand capture on grant, result load in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_a  <= '0;
            cap_b  <= '0;
            cap_op <= '0;
            cap_id <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
            id_q   <= '0;
        end else begin
            if (grant) begin
                cap_a  <= win_a;
                cap_b  <= win_b;
                cap_op <= win_op;
                cap_id <= win_id;
            end
            if (state == EXEC) begin
                res_q  <= alu_y;
                zero_q <= (alu_y == 8'h00);
                err_q  <= alu_err;
                id_q   <= cap_id;
            end
        end
    end

    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;
    assign bus.rsp_id     = id_q;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against
// a behavioural model of the round-robin ALU sequencer.
module tb_alu_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    alu_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_last;

    function automatic int rr_winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic int ref_alu(input int a, input int b, input int op,
                                   output bit err);
        err = 1'b0;
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return 255 - (a | b);
            default: begin
                err = 1'b1;
                return 0;
            end
        endcase
    endfunction

    task automatic set_req(input int i, input int a, input int b, input int op);
        bus.req_a[8*i +: 8]  = 8'(a);
        bus.req_b[8*i +: 8]  = 8'(b);
        bus.req_op[3*i +: 3] = 3'(op);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_busy got %b%b want 00", bus.rsp_valid, busy);
        end
        checks++;
        if (bus.rsp_result !== 8'h00 || bus.rsp_zero !== 1'b0 ||
            bus.rsp_err !== 1'b0 || bus.rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_rsp got res=%h z=%b e=%b id=%0d want 0",
                     bus.rsp_result, bus.rsp_zero, bus.rsp_err, bus.rsp_id);
        end
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        m_last = N - 1;
    endtask

    task automatic test_directed();
        int va[5] = '{8, 4, 0, 8, 255};
        int vb[5] = '{4, 8, 0, 4, 1};
        int vo[5] = '{0, 1, 0, 5, 6};
        int er[5] = '{12, 252, 0, 243, 0};
        int r;
        bit ee;
        for (int j = 0; j < 5; j++) begin
            r = j % N;
            ee = (vo[j] == 6);
            @(negedge clk);
            set_req(r, va[j], vb[j], vo[j]);
            bus.req_valid = '0;
            bus.req_valid[r] = 1'b1;
            bus.rsp_ready = 1'b1;
            #1;
            checks++;
            if (bus.req_ready !== (N'(1) << r)) begin
                errors++;
                $display("FAIL dir%0d_grant got %b want %b", j,
                         bus.req_ready, N'(1) << r);
            end
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_exec got v=%b busy=%b want v=0 busy=1",
                         j, bus.rsp_valid, busy);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'(er[j]) ||
                bus.rsp_zero !== (er[j] == 0) || bus.rsp_err !== ee ||
                bus.rsp_id !== 2'(r)) begin
                errors++;
                $display("FAIL dir%0d_rsp got v=%b res=%h z=%b e=%b id=%0d want v=1 res=%h z=%b e=%b id=%0d",
                         j, bus.rsp_valid, bus.rsp_result, bus.rsp_zero,
                         bus.rsp_err, bus.rsp_id, 8'(er[j]), er[j] == 0, ee, r);
            end
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_idle got busy=%b want 0", j, busy);
            end
            m_last = r;
        end
    endtask

    task automatic test_fairness();
        int ea[N];
        int eb[N];
        int eo[N];
        int id;
        int res;
        bit ee;
        logic [N-1:0] rdy;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            ea[i] = $urandom_range(255);
            eb[i] = $urandom_range(255);
            eo[i] = $urandom_range(5);
            set_req(i, ea[i], eb[i], eo[i]);
        end
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            rdy = '0;
            if (c % 2 == 0) rdy[(c / 2) % N] = 1'b1;
            checks++;
            if (bus.req_ready !== rdy) begin
                errors++;
                $display("FAIL fair_grant c%0d got %b want %b", c, bus.req_ready, rdy);
            end
            if (c >= 2 && c % 2 == 0) begin
                id = (c / 2 - 1) % N;
                res = ref_alu(ea[id], eb[id], eo[id], ee);
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(id) ||
                    bus.rsp_result !== 8'(res)) begin
                    errors++;
                    $display("FAIL fair_rsp c%0d got v=%b id=%0d res=%h want v=1 id=%0d res=%h",
                             c, bus.rsp_valid, bus.rsp_id, bus.rsp_result, id, 8'(res));
                end
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        @(negedge clk);
        m_last = 0;
    endtask

    task automatic test_backpressure();
        logic [7:0] hold;
        @(negedge clk);
        set_req(1, 100, 50, 1);
        set_req(2, 15, 240, 4);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant1 got %b want 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || busy !== 1'b1 ||
                bus.req_ready !== '0 || bus.rsp_result !== 8'd50 ||
                bus.rsp_id !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold c%0d got v=%b busy=%b rdy=%b res=%h id=%0d want 1 1 0000 32 1",
                         c, bus.rsp_valid, busy, bus.req_ready,
                         bus.rsp_result, bus.rsp_id);
            end
            if (c == 0) hold = bus.rsp_result;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.rsp_result !== hold) begin
            errors++;
            $display("FAIL bp_release got rdy=%b res=%h want 0100 %h",
                     bus.req_ready, bus.rsp_result, hold);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_exec got v=%b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 ||
            bus.rsp_result !== 8'hFF) begin
            errors++;
            $display("FAIL bp_rsp2 got v=%b id=%0d res=%h want 1 2 ff",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        @(negedge clk);
        m_last = 2;
    endtask

    task automatic test_random();
        int phase = 0;
        int c_a = 0;
        int c_b = 0;
        int c_op = 0;
        int c_id = 0;
        int e_res = 0;
        int e_id = 0;
        bit e_err = 1'b0;
        bit t_err;
        int g;
        int pa[N];
        int pb[N];
        int po[N];
        logic [N-1:0] v = '0;
        logic [N-1:0] er;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(2) == 0) begin
                    pa[i] = $urandom_range(255);
                    pb[i] = $urandom_range(255);
                    po[i] = $urandom_range(7);
                    set_req(i, pa[i], pb[i], po[i]);
                    v[i] = 1'b1;
                end else if (v[i] && $urandom_range(9) == 0) begin
                    v[i] = 1'b0;
                end
            end
            bus.req_valid = v;
            bus.rsp_ready = ($urandom_range(9) < 7);
            #1;
            g = -1;
            if (phase == 0 || (phase == 2 && bus.rsp_ready))
                g = rr_winner(v, m_last);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            checks++;
            if (bus.req_ready !== er) begin
                errors++;
                $display("FAIL rnd_grant cyc%0d got %b want %b", cyc, bus.req_ready, er);
            end
            checks++;
            if (bus.rsp_valid !== (phase == 2) || busy !== (phase != 0)) begin
                errors++;
                $display("FAIL rnd_status cyc%0d got v=%b busy=%b want v=%b busy=%b",
                         cyc, bus.rsp_valid, busy, phase == 2, phase != 0);
            end
            if (phase == 2) begin
                checks++;
                if (bus.rsp_result !== 8'(e_res) || bus.rsp_zero !== (e_res == 0) ||
                    bus.rsp_err !== e_err || bus.rsp_id !== 2'(e_id)) begin
                    errors++;
                    $display("FAIL rnd_rsp cyc%0d got res=%h z=%b e=%b id=%0d want res=%h z=%b e=%b id=%0d",
                             cyc, bus.rsp_result, bus.rsp_zero, bus.rsp_err,
                             bus.rsp_id, 8'(e_res), e_res == 0, e_err, e_id);
                end
            end
            if (g >= 0) begin
                c_a = pa[g];
                c_b = pb[g];
                c_op = po[g];
                c_id = g;
                m_last = g;
                v[g] = 1'b0;
                phase = 1;
            end else if (phase == 1) begin
                e_res = ref_alu(c_a, c_b, c_op, t_err);
                e_err = t_err;
                e_id = c_id;
                phase = 2;
            end else if (phase == 2 && bus.rsp_ready) begin
                phase = 0;
            end
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(3, 9, 9, 0);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rmid_grant got %b want 1000", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL rmid_async got v=%b busy=%b rdy=%b want 0 0 0000",
                     bus.rsp_valid, busy, bus.req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 8'h00) begin
            errors++;
            $display("FAIL rmid_held got v=%b res=%h want 0 00",
                     bus.rsp_valid, bus.rsp_result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, i, 1, 0);
        bus.req_valid = '1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_first got rdy=%b v=%b want 0001 0",
                     bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_stale got v=%b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 ||
            bus.rsp_result !== 8'd1) begin
            errors++;
            $display("FAIL rmid_rsp got v=%b id=%0d res=%h want 1 0 01",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fairness();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
